// File: rtl/wb_arbiter_24bit_pkg.sv
// Shared constants and state encoding for the write-back bus arbiter.
package wb_arb_pkg;

    localparam int DATA_W     = 24;
    localparam int BEAT_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_arbiter_24bit_if.sv
// Requester/consumer bundle around the write-back bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
import wb_arb_pkg::*;

interface wb_arbiter_24bit_if;
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              sel;
    logic              busy;

    modport slave (
        input  req_valid, req_data0, req_data1, out_ready,
        output req_ready, out_valid, out_data, sel, busy
    );

    modport master (
        output req_valid, req_data0, req_data1, out_ready,
        input  req_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/wb_arbiter_24bit_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie, the requester that did
// not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       winner,
    output logic       any
);
    always_comb begin
        any    = |valid;
        winner = valid[1];
        if (valid == 2'b11) begin
            winner = ~last;
        end
    end
endmodule

// File: rtl/wb_arbiter_24bit.sv
// Two-requester round-robin arbiter with burst limit feeding the write-back bus
// through a single-entry output stage. ARB_STATS_EN adds per-requester beat counters.
//   state | meaning
//   IDLE  | no grant; arbitrate among valid requesters (one cycle)
//   LOCK  | grant held by sel_q; beats flow while the output stage can accept
module wb_arbiter_24bit
    import wb_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_arbiter_24bit_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          beat_count0,
    output logic [15:0]          beat_count1
`endif
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

    arb_state_e              state_q, state_d;
    logic                    sel_q, sel_d;
    logic                    last_q, last_d;
    logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic [DATA_W-1:0]       sel_data;
    logic [1:0]              req_ready_c;
    logic                    can_accept;
    logic                    beat;
    logic                    pick_winner;
    logic                    pick_any;

    rr_pick2 u_pick (
        .valid  (bus.req_valid),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Shared 2:1 select path toward the result bus.
    assign sel_data = sel_q ? bus.req_data1 : bus.req_data0;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        req_ready_c = 2'b00;
        can_accept  = !out_valid_q || bus.out_ready;
        beat        = (state_q == LOCK) && bus.req_valid[sel_q] && can_accept;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_winner;
                    cnt_d   = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                req_ready_c[sel_q] = can_accept;
                if (!bus.req_valid[sel_q]) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        // Burst limit reached: hand over directly if the other side waits.
                        if (bus.req_valid[~sel_q]) begin
                            sel_d  = ~sel_q;
                            last_d = sel_q;
                        end
                    end else begin
                        cnt_d = cnt_q + BEAT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == LOCK);

`ifdef ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (beat && !sel_q) cnt0_d = cnt0_q + 16'd1;
        if (beat &&  sel_q) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign beat_count0 = cnt0_q;
    assign beat_count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_wb_arbiter_24bit.sv
// Scoreboard bench for wb_arbiter_24bit: sources push expected words, a
// negedge monitor pops and compares on every output handshake.
module tb_wb_arbiter_24bit;
    import wb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arbiter_24bit_if bus ();
`ifdef ARB_STATS_EN
    logic [15:0] bc0, bc1;
`endif

    wb_arbiter_24bit #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_STATS_EN
        ,
        .beat_count0 (bc0),
        .beat_count1 (bc1)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [23:0] exp_q[$];
    int hs_cyc[$];
    bit mon_en = 1'b1;

    int n0, n1, idx0, idx1;
    logic [23:0] base0, base1;
    bit hs0, hs1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = {(idx1 < n1), (idx0 < n0)};
        bus.req_data0 = base0 + idx0[23:0];
        bus.req_data1 = base1 + idx1[23:0];
    endtask

    task automatic start_src(input int a0, input logic [23:0] b0, input int a1, input logic [23:0] b1);
        n0 = a0; base0 = b0; idx0 = 0;
        n1 = a1; base1 = b1; idx1 = 0;
        hs0 = 1'b0; hs1 = 1'b0;
        drive();
    endtask

    task automatic sample_edge();
        @(negedge clk);
        hs0 = bus.req_valid[0] && bus.req_ready[0];
        hs1 = bus.req_valid[1] && bus.req_ready[1];
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (hs0) idx0++;
        if (hs1) idx1++;
        hs0 = 1'b0;
        hs1 = 1'b0;
        drive();
    endtask

    task automatic step();
        sample_edge();
        advance();
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || idx0 < n0 || idx1 < n1) && k < budget) begin
            step();
            k++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        start_src(0, 24'h0, 0, 24'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Cycle stamp
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor / scoreboard
    initial forever begin
        logic [23:0] e;
        @(negedge clk);
        if (rst_n && mon_en && bus.out_valid && bus.out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %0h expected no word", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", {8'h0, bus.out_data}, {8'h0, e});
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, k, hsn, gap;

        // Reset values
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        start_src(0, 24'h0, 0, 24'h0);
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_sel",       bus.sel, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        advance();

        // 1: single requester, latency 2
        exp_q.push_back(24'h00A5A5);
        c0 = cyc;
        start_src(1, 24'h00A5A5, 0, 24'h0);
        k = 0;
        sample_edge();
        while (!bus.out_valid && k < 10) begin
            advance();
            sample_edge();
            k++;
        end
        check("t1_latency", cyc - c0, 2);
        check("t1_sel", bus.sel, 0);
        check("t1_busy", bus.busy, 1);
        advance();
        drain("t1_drain", 20);

        // 3: tie after requester 0 won last -> requester 1 first
        exp_q.push_back(24'h100001);
        exp_q.push_back(24'h100002);
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'h000002);
        start_src(2, 24'h000001, 2, 24'h100001);
        drain("t3_drain", 40);

        // 2: both streaming, bursts of 4, direct handover
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h000001 + 24'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h100001 + 24'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h000005 + 24'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h100005 + 24'(i));
        hsn = hs_cyc.size();
        start_src(8, 24'h000001, 8, 24'h100001);
        drain("t2_drain", 60);
        check("t2_beats", hs_cyc.size() - hsn, 16);
        gap = (hs_cyc.size() >= hsn + 16) ? hs_cyc[hsn + 15] - hs_cyc[hsn] : 0;
        check("t2_no_gap", gap, 15);

        // 4: backpressure for 3 cycles after two beats
        for (int i = 0; i < 6; i++) exp_q.push_back(24'h000011 + 24'(i));
        start_src(6, 24'h000011, 0, 24'h0);
        repeat (3) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_edge();
            check("t4_req_ready", bus.req_ready, 0);
            check("t4_out_data",  bus.out_data, 24'h000012);
            check("t4_out_valid", bus.out_valid, 1);
            advance();
        end
        bus.out_ready = 1'b1;
        drain("t4_drain", 40);

        // 5: reset mid-burst discards the in-flight word
        exp_q.push_back(24'h000021);
        start_src(6, 24'h000021, 0, 24'h0);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_out_data",  bus.out_data, 0);
        check("t5_req_ready", bus.req_ready, 0);
        check("t5_busy",      bus.busy, 0);
        check("t5_sel",       bus.sel, 0);
        check("t5_sb_flush",  exp_q.size(), 0);
        start_src(0, 24'h0, 0, 24'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(24'h000031);
        exp_q.push_back(24'h100031);
        start_src(1, 24'h000031, 1, 24'h100031);
        drain("t5_drain", 30);

`ifdef ARB_STATS_EN
        // 6: counter wrap over 70000 beats
        do_reset();
        mon_en = 1'b0;
        start_src(70000, 24'h0, 0, 24'h0);
        k = 0;
        while (idx0 < n0 && k < 80000) begin
            step();
            k++;
        end
        repeat (3) step();
        check("t6_count0", bc0, 16'd4464);
        check("t6_count1", bc1, 16'd0);
        mon_en = 1'b1;
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
